// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ALU issue stage: request FIFO, external ALU drive, registered result (optional ALU_ILLEGAL_OP_TRAP_EN)
module alu_issue_stage #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_operation,
  input  logic [31:0]              in_left,
  input  logic [31:0]              in_right,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [2:0]               alu_operation,
  output logic [31:0]              alu_left,
  output logic [31:0]              alu_right,
  input  logic [31:0]              alu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     illegal_op_seen
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [2:0]       op_mem    [DEPTH];
  logic [31:0]      left_mem  [DEPTH];
  logic [31:0]      right_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem   [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_result_q;
  logic [TAG_W-1:0] out_tag_q;

  logic not_empty;
  logic push;
  logic pop;
  logic head_illegal;
  logic load;

  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q != FULL_COUNT);
  assign push      = in_valid && in_ready;
  assign pop       = not_empty && (!out_valid_q || out_ready);
  // A trapped illegal op leaves the FIFO but never reaches the output register.
  assign load      = pop && !head_illegal;

  assign alu_operation = not_empty ? op_mem[rd_ptr_q]    : 3'd0;
  assign alu_left      = not_empty ? left_mem[rd_ptr_q]  : 32'd0;
  assign alu_right     = not_empty ? right_mem[rd_ptr_q] : 32'd0;

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign count      = count_q;

`ifdef ALU_ILLEGAL_OP_TRAP_EN
  logic illegal_seen_q;

  assign head_illegal = not_empty && op_mem[rd_ptr_q][2];

  // Sticky flag: set by any trapped pop, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_seen_q <= 1'b0;
    end else if (pop && head_illegal) begin
      illegal_seen_q <= 1'b1;
    end
  end

  assign illegal_op_seen = illegal_seen_q;
`else
  assign head_illegal    = 1'b0;
  assign illegal_op_seen = 1'b0;
`endif

  // Next-state for pointers, occupancy and output-valid.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (load) out_valid_d = 1'b1;
    else if (out_valid_q && out_ready) out_valid_d = 1'b0;
  end

  // Payload storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr_q]    <= in_operation;
      left_mem[wr_ptr_q]  <= in_left;
      right_mem[wr_ptr_q] <= in_right;
      tag_mem[wr_ptr_q]   <= in_tag;
    end
  end

  // Control state; reset drops every queued request and any pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Output register captures the ALU result of the popped head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_result_q <= 32'd0;
      out_tag_q    <= '0;
    end else if (load) begin
      out_result_q <= alu_result;
      out_tag_q    <= tag_mem[rd_ptr_q];
    end
  end

endmodule
